// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmitter: FSM states, parity modes and
// data-length codes, plus small decode helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_EVEN     = 2'b01;
  localparam logic [1:0] PAR_ODD      = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  localparam logic [1:0] LEN_5 = 2'b00;
  localparam logic [1:0] LEN_6 = 2'b01;
  localparam logic [1:0] LEN_7 = 2'b10;
  localparam logic [1:0] LEN_8 = 2'b11;

  function automatic logic [3:0] data_len(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

  function automatic logic [7:0] len_mask(input logic [1:0] code);
    logic [7:0] m;
    case (code)
      LEN_5:   m = 8'h1F;
      LEN_6:   m = 8'h3F;
      LEN_7:   m = 8'h7F;
      LEN_8:   m = 8'hFF;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic parity_on(input logic [1:0] mode);
    logic en;
    case (mode)
      PAR_EVEN, PAR_ODD:      en = 1'b1;
      PAR_NONE, PAR_NONE_ALT: en = 1'b0;
      default:                en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/uart_tx_gen_if.sv
// Byte-stream input of the UART transmitter.
interface uart_tx_gen_if;
  // A byte moves on every rising clk edge where s_valid && s_ready; the
  // master holds s_data/s_valid stable until that edge, s_ready never
  // depends combinationally on s_valid.
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_fifo.sv
// Power-of-two circular FIFO with first-word fall-through read data.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_gen.sv
// Buffered UART transmitter: FIFO feeding a frame FSM with per-frame latched
// divisor, length, parity and stop configuration.
module uart_tx_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  uart_tx_gen_if.slave                  s,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop,
  output logic                          txd,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output uart_state_e                   state_dbg
);
  localparam int DEF_DIV = CLK_FREQ / BAUD;

  uart_state_e      state_q, state_d;
  logic [DIV_W-1:0] baud_q, baud_d, div_q, div_d, eff_div;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       data_q, data_d, fifo_dout;
  logic [1:0]       bits_q, bits_d;
  logic             par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
  logic             txd_q, busy_q, done_q;
  logic             line, done, pop, load, fifo_full, fifo_empty;
  logic             bit_end, last_data, last_stop;

  assign s.s_ready = !fifo_full;

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s.s_valid),
    .pop   (pop),
    .din   (s.s_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign eff_div   = (cfg_div <= DIV_W'(1)) ? DIV_W'(DEF_DIV) : cfg_div;
  assign bit_end   = (baud_q == div_q - DIV_W'(1));
  assign last_data = ({1'b0, bit_idx_q} == data_len(bits_q) - 4'd1);
  assign last_stop = (bit_idx_q[0] == stop2_q);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    div_d     = div_q;
    bits_d    = bits_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    stop2_d   = stop2_q;
    line      = 1'b1;
    done      = 1'b0;
    load      = 1'b0;
    pop       = 1'b0;
    if (state_q != ST_IDLE) baud_d = bit_end ? '0 : baud_q + 1'b1;
    case (state_q)
      ST_IDLE: if (!fifo_empty) load = 1'b1;
      ST_START: begin
        line = 1'b0;
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        line = data_q[bit_idx_q];
        if (bit_end) begin
          if (last_data) begin
            state_d   = par_en_q ? ST_PARITY : ST_STOP;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        // data_q is already masked to the frame length, so a full XOR works.
        line = (^data_q) ^ par_odd_q;
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        line = 1'b1;
        if (bit_end) begin
          if (last_stop) begin
            done = 1'b1;
            if (!fifo_empty) load = 1'b1;
            else             state_d = ST_IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      pop       = 1'b1;
      state_d   = ST_START;
      baud_d    = '0;
      data_d    = fifo_dout & len_mask(cfg_bits);
      div_d     = eff_div;
      bits_d    = cfg_bits;
      par_en_d  = parity_on(cfg_parity);
      par_odd_d = (cfg_parity == PAR_ODD);
      stop2_d   = cfg_stop;
    end
  end

  // Line, busy and done are registered together so they stay cycle-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      div_q     <= DIV_W'(DEF_DIV);
      bits_q    <= LEN_8;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      div_q     <= div_d;
      bits_q    <= bits_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      stop2_q   <= stop2_d;
      txd_q     <= line;
      busy_q    <= (state_q != ST_IDLE);
      done_q    <= done;
    end
  end

  assign txd       = txd_q;
  assign busy      = busy_q;
  assign tx_done   = done_q;
  assign state_dbg = state_q;
endmodule

// File: doc/uart_tx_gen.md
UART_TX_GEN -- requirements
Module: uart_tx_gen

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000: clock frequency, Hz.
REQ-002 Parameter BAUD, default 115_200: default baud rate; DEF_DIV = CLK_FREQ/BAUD.
REQ-003 Parameter DIV_W, default 16: width of runtime divisor.
REQ-004 Parameter FIFO_DEPTH, default 16: transmit FIFO entries, power of two, >=2.
REQ-005 Clock clk; reset rst_n, asynchronous, active-low.
REQ-006 clk  in  1  system clock, all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 s_data  in  8  byte to send, LSB first; bits above configured length ignored.
REQ-009 s_valid  in  1  s_data valid.
REQ-010 s_ready  out  1  FIFO not full; transfer when s_valid && s_ready on a rising edge.
REQ-011 cfg_div  in  DIV_W  clocks per bit; values 0 or 1 select DEF_DIV.
REQ-012 cfg_bits  in  2  data length: 00=5, 01=6, 10=7, 11=8.
REQ-013 cfg_parity  in  2  00=none, 01=even, 10=odd, 11=none.
REQ-014 cfg_stop  in  1  0=one stop bit, 1=two stop bits.
REQ-015 txd  out  1  serial line, idle high.
REQ-016 busy  out  1  frame in progress.
REQ-017 tx_done  out  1  one-cycle pulse at end of last stop bit.
REQ-018 level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.

Function
REQ-019 FIFO shall accept a word on every handshake cycle while not full; s_ready = (level != FIFO_DEPTH), combinational from registered level.
REQ-020 Simultaneous FIFO write and read shall leave level unchanged; write when full shall be impossible (s_ready low).
REQ-021 FSM states IDLE, START, DATA, PARITY, STOP; IDLE -> START when FIFO non-empty; START -> DATA; DATA -> PARITY if parity enabled else STOP after last data bit; PARITY -> STOP; STOP -> START if FIFO non-empty else IDLE.
REQ-022 On IDLE->START or STOP->START the word shall be popped and cfg_div, cfg_bits, cfg_parity, cfg_stop latched; config changes mid-frame shall not affect the current frame.
REQ-023 Each bit period shall last exactly the latched divisor in clock cycles; baud counter restarts at 0 on every frame start.
REQ-024 With FIFO empty and IDLE, a word accepted on edge N shall drive txd low from edge N+2.
REQ-025 txd levels: START=0, DATA=data[i] LSB first, PARITY=XOR of data bits (even) or its inverse (odd), STOP=1 for 1 or 2 bit periods.
REQ-026 Back-to-back frames shall have no idle gap: start bit immediately follows the last stop bit.
REQ-027 tx_done shall pulse on the last cycle of STOP; busy high in all states except IDLE.
REQ-028 txd shall be registered (glitch-free).

Reset
REQ-029 On rst_n low: txd=1, busy=0, tx_done=0, level=0, s_ready=1, FSM=IDLE, FIFO pointers and baud counter 0.
REQ-030 Reset mid-frame shall abort immediately, discard FIFO contents, drive txd high.

Structure
REQ-031 Package uart_pkg shall hold FSM state encoding, parity-mode and data-length code constants.
REQ-032 FIFO shall be sub-module uart_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, level).

Verification
REQ-033 cfg_div=4, 8N1, send 0x55 -> txd 0,1,0,1,0,1,0,1,0,1 each 4 cycles, tx_done once, busy low after.
REQ-034 cfg_div=4, 7E2, send 0x41 -> 0, 1000001, parity 0, stop 1,1; total 44 cycles.
REQ-035 cfg_div=4, 5O1, send 0xFF -> 0, 11111, parity 0, stop 1; bits 7:5 ignored.
REQ-036 Push 17 words with FIFO_DEPTH=16 while blocked -> s_ready low at level 16, no loss, frames contiguous with no idle gap.
REQ-037 Change cfg_div 4->8 mid-frame -> current frame stays 4 cycles/bit, next frame 8.
REQ-038 Assert rst_n low during DATA -> txd=1, level=0, busy=0 immediately; new frame after release correct.
